// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping for the R.O.E datapath,
// with a bounded wait on the data-memory ready handshake.
module alu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] inst,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       fetch_en,
  output logic [1:0] alu_src,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       done,
  output logic       err,
  output logic [2:0] state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [8:0]       ir;
  logic [CNT_W-1:0] mem_cnt;
  logic             mem_timeout;

  logic       is_special;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_halt;
  logic [1:0] dec_src;
  logic       mem_last;
  logic       unused_imm;

  // Immediate bits feed the datapath directly; the sequencer only needs the opcode field.
  assign unused_imm = ^ir[4:0];

  assign is_special = (ir[8:7] == 2'b11);
  assign is_load    = is_special && (ir[6:5] == 2'b00);
  assign is_store   = is_special && (ir[6:5] == 2'b01);
  assign is_branch  = is_special && (ir[6:5] == 2'b10);
  assign is_halt    = is_special && (ir[6:5] == 2'b11);

  always_comb begin
    dec_src = 2'b11;
    unique case (ir[8:7])
      2'b00: dec_src = 2'b10;
      2'b01: dec_src = 2'b01;
      2'b10: dec_src = 2'b00;
      default: begin
        if (is_load || is_store) dec_src = 2'b10;
        else if (is_branch)      dec_src = 2'b00;
        else                     dec_src = 2'b11;
      end
    endcase
  end

  // The final permitted MEM cycle is the one where MEM_TIMEOUT-1 cycles have already elapsed.
  assign mem_last = (mem_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    fetch_en    = 1'b0;
    alu_src     = 2'b11;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    done        = 1'b0;
    mem_timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fetch_en  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_src = dec_src;
        if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_branch) begin
          pc_load   = zero;
          pc_inc    = ~zero;
          state_nxt = S_FETCH;
        end else if (is_halt) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        alu_src   = dec_src;
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_nxt = S_WB;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (mem_last) begin
          mem_timeout = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_WB: begin
        alu_src   = dec_src;
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= 9'd0;
      mem_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) ir <= inst;
      if (state == S_EXEC)     mem_cnt <= '0;
      else if (state == S_MEM) mem_cnt <= mem_cnt + 1'b1;
      if (mem_timeout)
        err <= 1'b1;
      else if (start && (state == S_IDLE || state == S_DONE))
        err <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a literal vector table for the basic flows, then hand sequences and
// randomized instructions checked against a latency-rule model of the sequencer.
module tb_alu_seq_ctrl;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] inst;
  logic       zero;
  logic       mem_ready;
  logic       fetch_en;
  logic [1:0] alu_src;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       pc_inc;
  logic       pc_load;
  logic       done;
  logic       err;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .inst      (inst),
    .zero      (zero),
    .mem_ready (mem_ready),
    .fetch_en  (fetch_en),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .done      (done),
    .err       (err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Output vector layout: {fetch_en, alu_src, reg_write, mem_read, mem_write, pc_inc, pc_load, done, err, state}
  localparam logic [12:0] IDLE_O  = {1'b0, 2'b11, 7'b0, 3'd0};
  localparam logic [12:0] FETCH_O = {1'b1, 2'b11, 7'b0, 3'd1};
  localparam logic [12:0] DEC_O   = {1'b0, 2'b11, 7'b0, 3'd2};

  typedef struct {
    logic        rst;
    logic        st;
    logic        z;
    logic        rdy;
    logic [8:0]  in;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] pk(input logic fe, input logic [1:0] src, input logic rw,
                                     input logic mr, input logic mw, input logic pi,
                                     input logic pl, input logic dn, input logic er,
                                     input logic [2:0] st);
    return {fe, src, rw, mr, mw, pi, pl, dn, er, st};
  endfunction

  function automatic logic [12:0] exec_o(input logic [1:0] src);
    return pk(1'b0, src, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
  endfunction

  function automatic logic [12:0] wb_o(input logic [1:0] src);
    return pk(1'b0, src, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
  endfunction

  function automatic logic [12:0] done_o(input logic e);
    return pk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e, 3'd6);
  endfunction

  // ALU source select as listed in the instruction decode table.
  function automatic logic [1:0] ref_src(input logic [8:0] in);
    if (in[8:7] == 2'b00) return 2'b10;
    if (in[8:7] == 2'b01) return 2'b01;
    if (in[8:7] == 2'b10) return 2'b00;
    if (in[6:5] == 2'b10) return 2'b00;
    if (in[6:5] == 2'b11) return 2'b11;
    return 2'b10;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = pk(fetch_en, alu_src, reg_write, mem_read, mem_write, pc_inc, pc_load, done, err, state_o);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b required %b (fe src rw mr mw pi pl dn er st)", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, check, then move to the next falling edge.
  task automatic cyc(input logic st, input logic z, input logic rdy, input logic [8:0] in,
                     input logic [12:0] exp, input string name);
    start = st; zero = z; mem_ready = rdy; inst = in;
    #1;
    check(name, exp);
    @(negedge clk);
  endtask

  task automatic done_seq(input logic e);
    cyc(1'b0, rb(), rb(), 9'($urandom), done_o(e), "done_hold");
    cyc(1'b1, rb(), rb(), 9'($urandom), done_o(e), "done_start");
  endtask

  // Runs one instruction from FETCH. rdy_at = MEM cycle (1-based) carrying mem_ready; 0 or >T = never.
  task automatic do_instr(input logic [8:0] in, input logic z, input int rdy_at);
    logic [1:0] src;
    logic       mem_op;
    logic       ld;
    logic       ok;
    logic       rdy;
    int         n;
    src    = ref_src(in);
    mem_op = (in[8:6] == 3'b110);
    ld     = mem_op && !in[5];
    cyc(rb(), rb(), rb(), 9'($urandom), FETCH_O, "fetch");
    cyc(rb(), rb(), rb(), in, DEC_O, "decode");
    if (in[8:5] == 4'b1110) begin
      cyc(rb(), z, rb(), 9'($urandom),
          pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, !z, z, 1'b0, 1'b0, 3'd3), "branch_exec");
    end else if (in[8:5] == 4'b1111) begin
      cyc(rb(), rb(), rb(), 9'($urandom), exec_o(2'b11), "halt_exec");
      done_seq(1'b0);
    end else if (!mem_op) begin
      cyc(rb(), rb(), rb(), 9'($urandom), exec_o(src), "alu_exec");
      cyc(rb(), rb(), rb(), 9'($urandom), wb_o(src), "alu_wb");
    end else begin
      cyc(rb(), rb(), rb(), 9'($urandom), exec_o(2'b10), "mem_exec");
      ok = (rdy_at >= 1 && rdy_at <= T);
      n  = ok ? rdy_at : T;
      for (int k = 1; k <= n; k++) begin
        rdy = (k == rdy_at);
        cyc(rb(), rb(), rdy, 9'($urandom),
            pk(1'b0, 2'b10, 1'b0, ld, !ld, !ld && rdy, 1'b0, 1'b0, 1'b0, 3'd4), "mem_wait");
      end
      if (!ok)     done_seq(1'b1);
      else if (ld) cyc(rb(), rb(), rb(), 9'($urandom), wb_o(2'b10), "load_wb");
    end
  endtask

  vec_t tbl[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int r;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h000, IDLE_O};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, IDLE_O};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, FETCH_O};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0000011, DEC_O};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9'h1FF, exec_o(2'b10)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, wb_o(2'b10)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, FETCH_O};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b11_10_00000, DEC_O};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'h000,
                pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, FETCH_O};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b11_10_00000, DEC_O};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000,
                pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, FETCH_O};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b11_11_00000, DEC_O};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, exec_o(2'b11)};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'h000, done_o(1'b0)};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, done_o(1'b0)};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, done_o(1'b0)};

    reset = 1'b1; start = 1'b0; zero = 1'b0; mem_ready = 1'b0; inst = 9'd0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst;
      cyc(tbl[i].st, tbl[i].z, tbl[i].rdy, tbl[i].in, tbl[i].exp, $sformatf("table[%0d]", i));
    end

    do_instr(9'b01_000_1010, 1'b0, 0);
    do_instr(9'b10_000_0111, 1'b1, 0);
    do_instr(9'b11_00_00000, 1'b0, 3);
    do_instr(9'b11_01_00000, 1'b0, 0);
    do_instr(9'b11_00_00000, 1'b0, T);
    do_instr(9'b11_01_00000, 1'b1, 1);
    do_instr(9'b11_00_00000, 1'b0, 0);

    // Reset in the middle of a LOAD's memory wait.
    cyc(1'b0, 1'b0, 1'b0, 9'h000, FETCH_O, "rst_fetch");
    cyc(1'b0, 1'b0, 1'b0, 9'b11_00_00000, DEC_O, "rst_decode");
    cyc(1'b0, 1'b0, 1'b0, 9'h000, exec_o(2'b10), "rst_exec");
    cyc(1'b0, 1'b0, 1'b0, 9'h000,
        pk(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4), "rst_mem1");
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 9'h000,
        pk(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4), "rst_mem2");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 9'h000, IDLE_O, "rst_idle");
    cyc(1'b1, 1'b0, 1'b0, 9'h000, IDLE_O, "rst_idle_start");
    do_instr(9'b11_11_00000, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      r = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, T + 1));
      do_instr(9'($urandom), rb(), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
